// File: rtl/ps2_decoder.sv
// ps2_decoder: folds a Set-2 PS/2 scancode byte stream into single key events.
// E0 (extended), F0 (break) and E1 (pause) prefix sequences are collapsed
// into one 10-bit event {break, extended, code} and queued in a small FIFO.
// The FIFO is read by the CPU side over a ready/valid handshake.
// Optional feature macro: PS2_PAUSE_EVENT_EN. When it is defined, a complete
// E1 pause sequence produces the event 0x177. When it is undefined, the
// sequence is swallowed without producing any event.
module ps2_decoder #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic [9:0] event_o,
  output logic       event_valid_o,
  input  logic       event_ready_i,
  output logic       overflow_o,
  output logic       err_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    EXT,
    BRK,
    EXT_BRK,
    PAUSE
  } state_t;

  state_t     state;
  state_t     next_state;
  logic [2:0] skip_cnt;
  logic [2:0] next_skip;
  logic       push_req;
  logic [9:0] push_event;
  logic       err_next;
  logic       err_q;

  logic       is_key;
  logic       is_e0;
  logic       is_e1;
  logic       is_f0;
  logic       is_prefix;

  logic [9:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign is_key    = (data_i >= 8'h01) && (data_i <= 8'h83);
  assign is_e0     = (data_i == 8'hE0);
  assign is_e1     = (data_i == 8'hE1);
  assign is_f0     = (data_i == 8'hF0);
  assign is_prefix = is_e0 || is_e1 || is_f0;

  // Prefix state and the pause skip counter advance only on accepted bytes.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state    <= IDLE;
      skip_cnt <= 3'd0;
      err_q    <= 1'b0;
    end else begin
      state    <= next_state;
      skip_cnt <= next_skip;
      err_q    <= err_next;
    end
  end

  // Classify the incoming byte against the pending prefix and decide the event.
  always_comb begin
    next_state = state;
    next_skip  = skip_cnt;
    push_req   = 1'b0;
    push_event = 10'h000;
    err_next   = 1'b0;
    if (valid_i) begin
      case (state)
        IDLE: begin
          if (is_key) begin
            push_req   = 1'b1;
            push_event = {2'b00, data_i};
          end else if (is_e0) begin
            next_state = EXT;
          end else if (is_f0) begin
            next_state = BRK;
          end else if (is_e1) begin
            next_state = PAUSE;
            next_skip  = 3'd0;
          end
        end
        EXT: begin
          if (is_key) begin
            push_req   = 1'b1;
            push_event = {2'b01, data_i};
            next_state = IDLE;
          end else if (is_f0) begin
            next_state = EXT_BRK;
          end else begin
            err_next   = is_prefix;
            next_state = IDLE;
          end
        end
        BRK: begin
          if (is_key) begin
            push_req   = 1'b1;
            push_event = {2'b10, data_i};
          end
          err_next   = is_prefix;
          next_state = IDLE;
        end
        EXT_BRK: begin
          if (is_key) begin
            push_req   = 1'b1;
            push_event = {2'b11, data_i};
          end
          err_next   = is_prefix;
          next_state = IDLE;
        end
        PAUSE: begin
          if (skip_cnt == 3'd6) begin
            next_state = IDLE;
            next_skip  = 3'd0;
`ifdef PS2_PAUSE_EVENT_EN
            push_req   = 1'b1;
            push_event = 10'h177;
`endif
          end else begin
            next_skip = skip_cnt + 3'd1;
          end
        end
        default: begin
          next_state = IDLE;
          next_skip  = 3'd0;
        end
      endcase
    end
  end

  assign full    = (count == DEPTH_CNT);
  assign do_pop  = (count != '0) && event_ready_i;
  assign do_push = push_req && (!full || do_pop);

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_req && full && !do_pop) begin
        overflow_o <= 1'b1;
      end
    end
  end

  // Event storage; contents need no reset because occupancy gates visibility.
  always_ff @(posedge clk_i) begin
    if (!reset_i && do_push) begin
      mem[wr_ptr] <= push_event;
    end
  end

  assign event_valid_o = (count != '0);
  assign event_o       = event_valid_o ? mem[rd_ptr] : 10'h000;
  assign err_o         = err_q;

endmodule

// File: tb/tb_ps2_decoder.sv
// tb_ps2_decoder: directed and randomized bench for ps2_decoder.
// The reference model folds bytes using prefix flags and a queue.
// Honours PS2_PAUSE_EVENT_EN the same way as the design.
module tb_ps2_decoder;

  localparam int DEPTH = 8;
`ifdef PS2_PAUSE_EVENT_EN
  localparam bit PAUSE_EV = 1'b1;
`else
  localparam bit PAUSE_EV = 1'b0;
`endif

  logic       clk_i = 1'b0;
  logic       reset_i = 1'b1;
  logic [7:0] data_i = 8'h00;
  logic       valid_i = 1'b0;
  logic [9:0] event_o;
  logic       event_valid_o;
  logic       event_ready_i = 1'b0;
  logic       overflow_o;
  logic       err_o;

  int assert_cnt = 0;
  int fail_cnt   = 0;
  bit checking   = 1'b0;

  // Reference model state: pending prefix flags, pause bytes left, event queue.
  logic [9:0] model_q[$];
  bit         model_ovf = 1'b0;
  bit         model_err = 1'b0;
  bit         m_ext = 1'b0;
  bit         m_brk = 1'b0;
  int         m_pause = 0;

  ps2_decoder #(.FIFO_DEPTH(DEPTH)) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .data_i       (data_i),
    .valid_i      (valid_i),
    .event_o      (event_o),
    .event_valid_o(event_valid_o),
    .event_ready_i(event_ready_i),
    .overflow_o   (overflow_o),
    .err_o        (err_o)
  );

  // Free-running system clock.
  always #5 clk_i = ~clk_i;

  task automatic check_output(input string name, input logic [9:0] actual, input logic [9:0] expected);
    assert_cnt++;
    if (actual !== expected) begin
      fail_cnt++;
      $display("[TB] FAIL %s: actual=%h required=%h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic void model_byte(input logic [7:0] b, output bit has_ev,
                                     output logic [9:0] ev, output bit err);
    has_ev = 1'b0;
    ev     = 10'h000;
    err    = 1'b0;
    if (m_pause > 0) begin
      m_pause--;
      if (m_pause == 0 && PAUSE_EV) begin
        has_ev = 1'b1;
        ev     = 10'h177;
      end
    end else if (b >= 8'h01 && b <= 8'h83) begin
      has_ev = 1'b1;
      ev     = {m_brk, m_ext, b};
      m_ext  = 1'b0;
      m_brk  = 1'b0;
    end else if (b == 8'hE0 || b == 8'hE1) begin
      if (m_ext || m_brk) begin
        err   = 1'b1;
        m_ext = 1'b0;
        m_brk = 1'b0;
      end else if (b == 8'hE0) begin
        m_ext = 1'b1;
      end else begin
        m_pause = 7;
      end
    end else if (b == 8'hF0) begin
      if (m_brk) begin
        err   = 1'b1;
        m_ext = 1'b0;
        m_brk = 1'b0;
      end else begin
        m_brk = 1'b1;
      end
    end else begin
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endfunction

  // Advance the reference model on each clock edge from the bench's own inputs.
  always @(posedge clk_i) begin
    bit         pop;
    bit         has_ev;
    bit         e;
    logic [9:0] ev;
    if (reset_i) begin
      model_q.delete();
      model_ovf = 1'b0;
      model_err = 1'b0;
      m_ext     = 1'b0;
      m_brk     = 1'b0;
      m_pause   = 0;
    end else begin
      pop    = (model_q.size() > 0) && event_ready_i;
      has_ev = 1'b0;
      e      = 1'b0;
      ev     = 10'h000;
      if (valid_i) model_byte(data_i, has_ev, ev, e);
      model_err = e;
      if (pop) void'(model_q.pop_front());
      if (has_ev) begin
        if (model_q.size() < DEPTH) model_q.push_back(ev);
        else model_ovf = 1'b1;
      end
    end
  end

  // Compare DUT outputs against the model every cycle, mid-period.
  always @(negedge clk_i) begin
    if (checking) begin
      check_output("cmp_valid", {9'b0, event_valid_o}, {9'b0, (model_q.size() > 0)});
      check_output("cmp_overflow", {9'b0, overflow_o}, {9'b0, model_ovf});
      check_output("cmp_err", {9'b0, err_o}, {9'b0, model_err});
      if (model_q.size() > 0) check_output("cmp_event", event_o, model_q[0]);
    end
  end

  task automatic apply_stimulus(input logic [7:0] b);
    @(negedge clk_i);
    data_i  = b;
    valid_i = 1'b1;
    @(negedge clk_i);
    valid_i = 1'b0;
  endtask

  task automatic pop_expect(input string name, input logic [9:0] expected);
    @(negedge clk_i);
    check_output({name, "_valid"}, {9'b0, event_valid_o}, 10'd1);
    check_output(name, event_o, expected);
    event_ready_i = 1'b1;
    @(negedge clk_i);
    event_ready_i = 1'b0;
  endtask

  task automatic expect_empty(input string name);
    @(negedge clk_i);
    check_output(name, {9'b0, event_valid_o}, 10'd0);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    reset_i       = 1'b1;
    valid_i       = 1'b0;
    event_ready_i = 1'b0;
    repeat (2) @(negedge clk_i);
    reset_i = 1'b0;
  endtask

  // Directed scenarios with literal expectations, then a randomized stream.
  initial begin
    int r;
    repeat (3) @(negedge clk_i);
    reset_i  = 1'b0;
    checking = 1'b1;
    check_output("rst_valid", {9'b0, event_valid_o}, 10'd0);
    check_output("rst_overflow", {9'b0, overflow_o}, 10'd0);
    check_output("rst_err", {9'b0, err_o}, 10'd0);
    check_output("rst_event", event_o, 10'h000);
    repeat (10) @(negedge clk_i);

    // Make, break and a status byte.
    apply_stimulus(8'h1C);
    apply_stimulus(8'hF0);
    apply_stimulus(8'h1C);
    apply_stimulus(8'hAA);
    pop_expect("make_1c", 10'h01C);
    pop_expect("break_1c", 10'h21C);
    expect_empty("status_aa_no_event");

    // Extended make/break.
    apply_stimulus(8'hE0); apply_stimulus(8'h75);
    apply_stimulus(8'hE0); apply_stimulus(8'hF0); apply_stimulus(8'h75);
    apply_stimulus(8'hE0); apply_stimulus(8'h12);
    apply_stimulus(8'hE0); apply_stimulus(8'h7C);
    pop_expect("ext_make_75", 10'h175);
    pop_expect("ext_break_75", 10'h375);
    pop_expect("ext_make_12", 10'h112);
    pop_expect("ext_make_7c", 10'h17C);
    expect_empty("ext_drained");

    // Overflow: nine pushes into an eight-entry FIFO.
    for (int i = 0; i < 9; i++) apply_stimulus(8'(8'h15 + i));
    @(negedge clk_i);
    check_output("overflow_set", {9'b0, overflow_o}, 10'd1);
    for (int i = 0; i < 8; i++) pop_expect("ovf_drain", 10'(8'h15 + i));
    expect_empty("ovf_drained");

    // Full FIFO with simultaneous push and pop keeps order, no overflow.
    do_reset();
    for (int i = 0; i < 8; i++) apply_stimulus(8'(8'h20 + i));
    @(negedge clk_i);
    data_i        = 8'h30;
    valid_i       = 1'b1;
    event_ready_i = 1'b1;
    @(negedge clk_i);
    valid_i       = 1'b0;
    event_ready_i = 1'b0;
    check_output("full_pushpop_no_ovf", {9'b0, overflow_o}, 10'd0);
    for (int i = 1; i < 8; i++) pop_expect("full_drain", 10'(8'h20 + i));
    pop_expect("full_drain_last", 10'h030);
    expect_empty("full_drained");

    // Prefix violation: F0 then E0.
    apply_stimulus(8'hF0);
    @(negedge clk_i);
    data_i  = 8'hE0;
    valid_i = 1'b1;
    @(negedge clk_i);
    valid_i = 1'b0;
    check_output("err_pulse", {9'b0, err_o}, 10'd1);
    @(negedge clk_i);
    check_output("err_one_cycle", {9'b0, err_o}, 10'd0);
    check_output("err_no_event", {9'b0, event_valid_o}, 10'd0);
    apply_stimulus(8'h1C);
    pop_expect("after_err_1c", 10'h01C);

    // Reset between E0 and 75 discards the extended prefix.
    apply_stimulus(8'hE0);
    do_reset();
    apply_stimulus(8'h75);
    pop_expect("after_reset_75", 10'h075);
    expect_empty("after_reset_drained");

    // Pause sequence followed by a make code.
    apply_stimulus(8'hE1); apply_stimulus(8'h14); apply_stimulus(8'h77);
    apply_stimulus(8'hE1); apply_stimulus(8'hF0); apply_stimulus(8'h14);
    apply_stimulus(8'hF0); apply_stimulus(8'h77);
    apply_stimulus(8'h1C);
    if (PAUSE_EV) pop_expect("pause_event", 10'h177);
    pop_expect("after_pause_1c", 10'h01C);
    expect_empty("pause_drained");

    // Randomized stream with back-to-back bytes, random ready and resets.
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk_i);
      reset_i       = ($urandom_range(0, 299) == 0);
      valid_i       = ($urandom_range(0, 99) < 60);
      event_ready_i = ($urandom_range(0, 99) < 40);
      r = $urandom_range(0, 9);
      case (r)
        0: data_i = 8'hE0;
        1: data_i = 8'hF0;
        2: data_i = ($urandom_range(0, 2) == 0) ? 8'hE1 : 8'hE0;
        3: begin
          case ($urandom_range(0, 5))
            0: data_i = 8'h00;
            1: data_i = 8'hAA;
            2: data_i = 8'hFA;
            3: data_i = 8'h84;
            4: data_i = 8'hE2;
            default: data_i = 8'hFF;
          endcase
        end
        default: data_i = 8'($urandom_range(1, 131));
      endcase
    end
    @(negedge clk_i);
    reset_i       = 1'b0;
    valid_i       = 1'b0;
    event_ready_i = 1'b1;
    repeat (12) @(negedge clk_i);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
